run_monitor: RTL and testbench
==============================

RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning data-memory word width.
REQ-003 SHALL have parameter PC_W, default 15, meaning program-counter width.
REQ-004 SHALL have parameter NUM_WATCH, default 4, range 1..16, meaning number of watched memory words.
REQ-005 SHALL have parameter WATCH_ADDRS, default {15'd16,15'd2,15'd1,15'd0}, meaning packed NUM_WATCH*ADDR_W watch addresses, channel 0 in the LSBs.
REQ-006 SHALL have parameter MAX_CYCLES, default 50, meaning the run-cycle timeout (>=1).
REQ-007 SHALL have parameter HALT_REPEAT, default 4, meaning consecutive loop cycles that declare a halt.
REQ-008 SHALL have parameter RESET_CYCLES, default 2, meaning the CPU reset hold length (>=1).
REQ-009 SHALL have ports:
 clock  in  1  sole clock, rising edge;
 reset  in  1  asynchronous, active-low;
 start  in  1  launches a run (pulse);
 pc  in  PC_W  CPU program counter;
 mem_we  in  1  CPU data-memory write enable;
 mem_addr  in  ADDR_W  CPU write address;
 mem_data  in  DATA_W  CPU write data;
 cpu_reset  out  1  active-high reset to the CPU;
 busy  out  1  high in RESET or RUN;
 done  out  1  high in DONE;
 done_cause  out  2  00 none, 01 halt, 10 timeout;
 cycle_count  out  16  RUN cycles elapsed;
 watch_hit  out  NUM_WATCH  channel written this run;
 watch_data  out  NUM_WATCH*DATA_W  last value written per channel;
 write_count  out  16  total CPU writes this run.

Function
REQ-010 SHALL implement the FSM states IDLE, RESET, RUN and DONE.
REQ-011 SHALL transition IDLE->RESET or DONE->RESET on start, clearing cycle_count, watch_hit, watch_data, write_count, done_cause and the halt counter in that same edge.
REQ-012 SHALL hold cpu_reset=1 in IDLE and RESET and 0 in RUN and DONE, leave RESET after exactly RESET_CYCLES cycles, and ignore start in RESET and RUN.
REQ-013 SHALL increment cycle_count once per RUN cycle, saturating at 16'hFFFF.
REQ-014 SHALL capture, in RUN only, mem_data into channel k when mem_we=1 and mem_addr==WATCH_ADDRS[k], setting watch_hit[k] with one-cycle latency; duplicate watch addresses all capture.
REQ-015 SHALL increment write_count per RUN cycle with mem_we=1, saturating, and ignore writes outside RUN.
REQ-016 SHALL delay pc by two registered stages, increment a halt counter when pc==pc_d2 (one- or two-instruction self loop), and clear it otherwise; the first two RUN cycles never count.
REQ-017 SHALL go RUN->DONE with done_cause=01 when the halt counter reaches HALT_REPEAT.
REQ-018 SHALL go RUN->DONE with done_cause=10 when cycle_count reaches MAX_CYCLES.
REQ-019 SHALL let halt win when halt and timeout occur on the same edge.
REQ-020 SHALL hold all captured values stable in DONE until the next start.

Reset
REQ-021 SHALL, on reset low, asynchronously enter IDLE with cpu_reset=1, busy=0, done=0, done_cause=00, and all counters, watch_hit and watch_data zero.
REQ-022 SHALL, on reset asserted mid-run, abort immediately with no partial done.

Configuration
REQ-023 SHALL, with RUN_MONITOR_TRACE_EN defined, drive write_count and emit one $display per captured watch write (cycle, channel, address, data).
REQ-024 SHALL, without RUN_MONITOR_TRACE_EN, tie write_count to 0, emit no display output and add no write-count logic.

Structure
REQ-025 SHALL place the state enum and done_cause codes (CAUSE_NONE, CAUSE_HALT, CAUSE_TIMEOUT) in package run_monitor_pkg.
REQ-026 SHALL implement each channel as sub-module run_monitor_watch (address compare, data register, hit flag), generated NUM_WATCH times.

Verification
REQ-027 SHALL verify: reset low mid-RUN -> next sample IDLE, cpu_reset=1, watch_hit=0, cycle_count=0.
REQ-028 SHALL verify: start, then pc alternating 5,6 forever -> done_cause=01 after RESET_CYCLES+2+HALT_REPEAT cycles, cycle_count=6.
REQ-029 SHALL verify: start, pc incrementing, MAX_CYCLES=50 -> done_cause=10 with cycle_count=50.
REQ-030 SHALL verify: writes 3->addr 0, 7->addr 16, 9->addr 0 -> watch_data ch0=9, ch3=7, watch_hit=4'b1001, write_count=3 (TRACE_EN).
REQ-031 SHALL verify: MAX_CYCLES=6, HALT_REPEAT=4, pc constant -> both conditions on the same edge -> done_cause=01.
REQ-032 SHALL verify: write to addr 0 during RESET, then start in DONE -> capture ignored and all results cleared before the second run.

Source files
------------

// File: rtl/run_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : run_monitor_pkg
// Brief    : Shared FSM state encoding and done-cause codes for run_monitor.
// Revision : 1.0 - initial release
// ============================================================================
package run_monitor_pkg;

    // Run-control states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Reason the last run ended
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_HALT    = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/run_monitor_watch.sv
`default_nettype none
// ============================================================================
// Module   : run_monitor_watch
// Brief    : One watch channel: compares the CPU write address against a fixed
//            address and keeps the last value written there plus a hit flag.
// Revision : 1.0 - initial release
// ============================================================================
module run_monitor_watch
    import run_monitor_pkg::*;
#(
    parameter int              ADDR_W     = 15,
    parameter int              DATA_W     = 16,
    parameter logic [ADDR_W-1:0] WATCH_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    logic              w_match;
    logic              r_hit;
    logic [DATA_W-1:0] r_data;

    assign w_match = i_enable && i_we && (i_addr == WATCH_ADDR);

    // Latch the most recent matching write; a new run wipes the channel
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hit  <= 1'b0;
            r_data <= '0;
        end else if (i_clear) begin
            r_hit  <= 1'b0;
            r_data <= '0;
        end else if (w_match) begin
            r_hit  <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_hit  = r_hit;
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : run_monitor
// Brief    : Drives a CPU through reset and a bounded run, detects self-loop
//            halts or timeout, and records writes to a set of watched words.
//            Define RUN_MONITOR_TRACE_EN to enable the write counter and a
//            simulation trace of every captured watch write.
// Revision : 1.0 - initial release
// ============================================================================
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 16,
    parameter int PC_W         = 15,
    parameter int NUM_WATCH    = 4,
    parameter logic [NUM_WATCH*ADDR_W-1:0] WATCH_ADDRS = {15'd16, 15'd2, 15'd1, 15'd0},
    parameter int MAX_CYCLES   = 50,
    parameter int HALT_REPEAT  = 4,
    parameter int RESET_CYCLES = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [PC_W-1:0]             pc,
    input  logic                        mem_we,
    input  logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_data,
    output logic                        cpu_reset,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  done_cause,
    output logic [15:0]                 cycle_count,
    output logic [NUM_WATCH-1:0]        watch_hit,
    output logic [NUM_WATCH*DATA_W-1:0] watch_data,
    output logic [15:0]                 write_count
);

    localparam logic [15:0] c_rst_last  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] c_max_last  = 16'(MAX_CYCLES - 1);
    localparam logic [15:0] c_halt_last = 16'(HALT_REPEAT - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [15:0]     r_rst_cnt;
    logic [15:0]     r_cycle_count;
    logic [15:0]     r_halt_cnt;
    logic [1:0]      r_done_cause;
    logic [PC_W-1:0] r_pc_d1;
    logic [PC_W-1:0] r_pc_d2;

    logic w_start_ok;
    logic w_in_run;
    logic w_rst_done;
    logic w_loop;
    logic w_halt;
    logic w_timeout;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_in_run   = (r_state == RUN);
    assign w_rst_done = (r_state == RESET) && (r_rst_cnt == c_rst_last);
    // pc_d2 still holds pre-RUN history in the first two RUN cycles
    assign w_loop     = w_in_run && (r_cycle_count >= 16'd2) && (pc == r_pc_d2);
    assign w_halt     = w_loop && (r_halt_cnt == c_halt_last);
    assign w_timeout  = w_in_run && (r_cycle_count == c_max_last);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_next_state = r_state;
        cpu_reset    = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = RESET;
            end
            RESET: begin
                busy = 1'b1;
                if (w_rst_done) w_next_state = RUN;
            end
            RUN: begin
                cpu_reset = 1'b0;
                busy      = 1'b1;
                if (w_halt || w_timeout) w_next_state = DONE;
            end
            DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (start) w_next_state = RESET;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Run counters, pc history and end-of-run cause
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rst_cnt     <= '0;
            r_cycle_count <= '0;
            r_halt_cnt    <= '0;
            r_done_cause  <= CAUSE_NONE;
            r_pc_d1       <= '0;
            r_pc_d2       <= '0;
        end else begin
            r_pc_d1 <= pc;
            r_pc_d2 <= r_pc_d1;
            if (w_start_ok) begin
                r_rst_cnt     <= '0;
                r_cycle_count <= '0;
                r_halt_cnt    <= '0;
                r_done_cause  <= CAUSE_NONE;
            end else begin
                if (r_state == RESET) r_rst_cnt <= r_rst_cnt + 16'd1;
                if (w_in_run) begin
                    if (r_cycle_count != 16'hFFFF) r_cycle_count <= r_cycle_count + 16'd1;
                    r_halt_cnt <= w_loop ? (r_halt_cnt + 16'd1) : 16'd0;
                    // halt takes priority when both end conditions coincide
                    if (w_halt)         r_done_cause <= CAUSE_HALT;
                    else if (w_timeout) r_done_cause <= CAUSE_TIMEOUT;
                end
            end
        end
    end

    assign cycle_count = r_cycle_count;
    assign done_cause  = r_done_cause;

    genvar k;
    generate
        for (k = 0; k < NUM_WATCH; k++) begin : g_watch
            run_monitor_watch #(
                .ADDR_W     (ADDR_W),
                .DATA_W     (DATA_W),
                .WATCH_ADDR (WATCH_ADDRS[k*ADDR_W +: ADDR_W])
            ) u_watch (
                .clock    (clock),
                .reset    (reset),
                .i_clear  (w_start_ok),
                .i_enable (w_in_run),
                .i_we     (mem_we),
                .i_addr   (mem_addr),
                .i_data   (mem_data),
                .o_hit    (watch_hit[k]),
                .o_data   (watch_data[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

`ifdef RUN_MONITOR_TRACE_EN
    logic [15:0] r_write_count;

    // Count every CPU write seen during RUN, saturating
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_write_count <= '0;
        end else if (w_start_ok) begin
            r_write_count <= '0;
        end else if (w_in_run && mem_we && (r_write_count != 16'hFFFF)) begin
            r_write_count <= r_write_count + 16'd1;
        end
    end

    assign write_count = r_write_count;

    // Trace each watch capture as it happens
    always @(posedge clock) begin
        if (reset && w_in_run && mem_we) begin
            for (int i = 0; i < NUM_WATCH; i++) begin
                if (mem_addr == WATCH_ADDRS[i*ADDR_W +: ADDR_W]) begin
                    $display("run_monitor trace: cycle=%0d ch=%0d addr=%0h data=%0h",
                             r_cycle_count, i, mem_addr, mem_data);
                end
            end
        end
    end
`else
    assign write_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_monitor
// Brief    : Self-checking bench for run_monitor. A plan of per-RUN-cycle
//            inputs is turned into an expected run outcome, queued, and then
//            driven; a monitor compares each outcome when done rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_monitor;

    localparam int RC   = 2;   // reset hold length of both instances
    localparam int HREP = 4;

    typedef struct {
        logic [1:0]  cause;
        logic [15:0] cycles;
        logic [3:0]  hit;
        logic [63:0] data;
        logic [15:0] wcount;
        int          last;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [14:0] pc;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_data;

    logic        cpu_reset_a, busy_a, done_a, cpu_reset_b, busy_b, done_b;
    logic [1:0]  cause_a, cause_b;
    logic [15:0] cyc_a, cyc_b, wc_a, wc_b;
    logic [3:0]  hit_a, hit_b;
    logic [63:0] wd_a, wd_b;

    int n_total = 0;
    int n_pass  = 0;

    exp_t exp_a[$];
    exp_t exp_b[$];

    logic [14:0] pl_pc[64];
    bit          pl_we[64];
    logic [14:0] pl_addr[64];
    logic [15:0] pl_data[64];
    int          waddr[4] = '{0, 1, 2, 16};

    always #5 clock = ~clock;

    run_monitor u_dut_a (
        .clock(clock), .reset(reset), .start(start_a), .pc(pc),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_reset(cpu_reset_a), .busy(busy_a), .done(done_a),
        .done_cause(cause_a), .cycle_count(cyc_a), .watch_hit(hit_a),
        .watch_data(wd_a), .write_count(wc_a)
    );

    run_monitor #(.MAX_CYCLES(6)) u_dut_b (
        .clock(clock), .reset(reset), .start(start_b), .pc(pc),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_reset(cpu_reset_b), .busy(busy_b), .done(done_b),
        .done_cause(cause_b), .cycle_count(cyc_b), .watch_hit(hit_b),
        .watch_data(wd_b), .write_count(wc_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic snap(input bit b, output logic cr, output logic bs, output logic dn,
                        output logic [1:0] cs, output logic [15:0] cc, output logic [3:0] wh,
                        output logic [63:0] wd, output logic [15:0] wc);
        cr = b ? cpu_reset_b : cpu_reset_a;
        bs = b ? busy_b      : busy_a;
        dn = b ? done_b      : done_a;
        cs = b ? cause_b     : cause_a;
        cc = b ? cyc_b       : cyc_a;
        wh = b ? hit_b       : hit_a;
        wd = b ? wd_b        : wd_a;
        wc = b ? wc_b        : wc_a;
    endtask

    // Outcome of a run from the plan: halt after HREP consecutive cycles whose
    // pc equals the pc two cycles earlier, otherwise timeout after maxc cycles.
    function automatic exp_t model(input int maxc);
        exp_t e;
        int   loops = 0;
        int   wc = 0;
        e.cause = 2'b00; e.cycles = 0; e.hit = 0; e.data = 0; e.last = maxc - 1;
        for (int i = 0; i < maxc; i++) begin
            if (pl_we[i]) begin
                wc++;
                for (int k = 0; k < 4; k++)
                    if (int'(pl_addr[i]) == waddr[k]) begin
                        e.hit[k] = 1'b1;
                        e.data[k*16 +: 16] = pl_data[i];
                    end
            end
            if (i >= 2 && pl_pc[i] == pl_pc[i-2]) loops++;
            else loops = 0;
            if (loops == HREP) begin
                e.cause = 2'b01; e.cycles = 16'(i + 1); e.last = i;
                break;
            end
            if (i + 1 == maxc) begin
                e.cause = 2'b10; e.cycles = 16'(i + 1); e.last = i;
            end
        end
`ifdef RUN_MONITOR_TRACE_EN
        e.wcount = 16'(wc);
`else
        e.wcount = 16'd0;
`endif
        return e;
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < 64; i++) begin
            pl_pc[i] = 15'(300 + i); pl_we[i] = 0; pl_addr[i] = 15'd5; pl_data[i] = 16'd0;
        end
    endtask

    task automatic gen_random(input int loop_pct);
        for (int i = 0; i < 64; i++) begin
            if (i >= 2 && $urandom_range(99) < loop_pct) pl_pc[i] = pl_pc[i-2];
            else pl_pc[i] = 15'($urandom_range(0, 7));
            pl_we[i] = ($urandom_range(1) == 1);
            case ($urandom_range(5))
                0: pl_addr[i] = 15'd0;
                1: pl_addr[i] = 15'd1;
                2: pl_addr[i] = 15'd2;
                3: pl_addr[i] = 15'd16;
                4: pl_addr[i] = 15'd3;
                default: pl_addr[i] = 15'($urandom);
            endcase
            pl_data[i] = 16'($urandom);
        end
    endtask

    task automatic cmp_item(input string tag, input bit b, input exp_t e);
        logic cr, bs, dn; logic [1:0] cs; logic [15:0] cc, wc; logic [3:0] wh; logic [63:0] wd;
        snap(b, cr, bs, dn, cs, cc, wh, wd, wc);
        check({tag, "_cause"},  64'(cs), 64'(e.cause));
        check({tag, "_cycles"}, 64'(cc), 64'(e.cycles));
        check({tag, "_hit"},    64'(wh), 64'(e.hit));
        check({tag, "_data"},   wd,      e.data);
        check({tag, "_wcount"}, 64'(wc), 64'(e.wcount));
        check({tag, "_status"}, {61'd0, cr, bs, dn}, 64'b001);
    endtask

    // Issue one run from the current plan; abort_at >= 0 pulls reset low
    // after that many RUN cycles instead of letting the run finish.
    task automatic run_plan(input bit b, input exp_t e, input int abort_at);
        logic cr, bs, dn; logic [1:0] cs; logic [15:0] cc, wc; logic [3:0] wh; logic [63:0] wd;
        logic [3:0] hs = 4'd0;
        if (abort_at < 0) begin
            if (b) exp_b.push_back(e); else exp_a.push_back(e);
        end
        @(negedge clock);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0; start_b = 1'b0;
        snap(b, cr, bs, dn, cs, cc, wh, wd, wc);
        check("rst_phase_status", {61'd0, cr, bs, dn}, 64'b110);
        check("rst_phase_cleared", {cs, cc, wh, wc}, 64'd0);
        check("rst_phase_data", wd, 64'd0);
        for (int r = 0; r < RC; r++) begin
            pc = 15'($urandom); mem_we = 1'b1; mem_addr = 15'd0; mem_data = 16'($urandom);
            if (b) start_b = ($urandom_range(1) == 1); else start_a = ($urandom_range(1) == 1);
            @(negedge clock);
        end
        for (int i = 0; i <= e.last; i++) begin
            snap(b, cr, bs, dn, cs, cc, wh, wd, wc);
            if (i == 0) check("run_entry_status", {61'd0, cr, bs, dn}, 64'b010);
            check("run_cycle_count", 64'(cc), 64'(i));
            check("run_hit_latency", 64'(wh), 64'(hs));
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                snap(b, cr, bs, dn, cs, cc, wh, wd, wc);
                check("abort_status", {61'd0, cr, bs, dn}, 64'b100);
                check("abort_counts", {cs, cc, wh, wc}, 64'd0);
                check("abort_data", wd, 64'd0);
                @(negedge clock);
                reset = 1'b1; start_a = 1'b0; start_b = 1'b0; mem_we = 1'b0;
                return;
            end
            pc = pl_pc[i]; mem_we = pl_we[i]; mem_addr = pl_addr[i]; mem_data = pl_data[i];
            if (b) start_b = ($urandom_range(3) == 0); else start_a = ($urandom_range(3) == 0);
            for (int k = 0; k < 4; k++)
                if (pl_we[i] && int'(pl_addr[i]) == waddr[k]) hs[k] = 1'b1;
            @(negedge clock);
        end
        start_a = 1'b0; start_b = 1'b0;
        repeat (5) begin
            pc = 15'($urandom); mem_we = ($urandom_range(1) == 1);
            mem_addr = ($urandom_range(1) == 1) ? 15'd0 : 15'd16; mem_data = 16'($urandom);
            @(negedge clock);
        end
        mem_we = 1'b0;
    endtask

    // Monitor: compare each run outcome when done rises, and again a few
    // cycles later to confirm the results are held in DONE.
    initial begin : monitor
        bit   pa = 0, pb = 0;
        int   ha = 0, hb = 0;
        exp_t la, lb;
        forever begin
            @(negedge clock);
            if (done_a && !pa) begin
                if (exp_a.size() == 0) begin
                    n_total++;
                    $display("FAIL a_unexpected_done: done=1 with no run outstanding");
                end else begin
                    la = exp_a.pop_front(); cmp_item("a_done", 1'b0, la); ha = 3;
                end
            end else if (ha > 0) begin
                ha--;
                if (ha == 0 && done_a) cmp_item("a_hold", 1'b0, la);
            end
            if (done_b && !pb) begin
                if (exp_b.size() == 0) begin
                    n_total++;
                    $display("FAIL b_unexpected_done: done=1 with no run outstanding");
                end else begin
                    lb = exp_b.pop_front(); cmp_item("b_done", 1'b1, lb); hb = 3;
                end
            end else if (hb > 0) begin
                hb--;
                if (hb == 0 && done_b) cmp_item("b_hold", 1'b1, lb);
            end
            pa = done_a; pb = done_b;
        end
    end

    // Stimulus sequence
    initial begin : driver
        exp_t e;
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        pc = '0; mem_we = 1'b0; mem_addr = '0; mem_data = '0;
        repeat (3) @(negedge clock);
        check("reset_status_a", {61'd0, cpu_reset_a, busy_a, done_a}, 64'b100);
        check("reset_counts_a", {cause_a, cyc_a, hit_a, wc_a}, 64'd0);
        check("reset_data_a", wd_a, 64'd0);
        check("reset_status_b", {61'd0, cpu_reset_b, busy_b, done_b}, 64'b100);
        reset = 1'b1;
        @(negedge clock);

        // two-instruction loop 5,6,5,6...
        clear_plan();
        for (int i = 0; i < 64; i++) pl_pc[i] = (i % 2 == 1) ? 15'd6 : 15'd5;
        e = model(50); run_plan(1'b0, e, -1);

        // straight-line pc, no loop: timeout
        clear_plan();
        for (int i = 0; i < 64; i++) pl_pc[i] = 15'(100 + i);
        e = model(50); run_plan(1'b0, e, -1);

        // watched writes, including a repeated address, restarted from DONE
        clear_plan();
        pl_we[1] = 1; pl_addr[1] = 15'd0;  pl_data[1] = 16'd3;
        pl_we[3] = 1; pl_addr[3] = 15'd16; pl_data[3] = 16'd7;
        pl_we[5] = 1; pl_addr[5] = 15'd0;  pl_data[5] = 16'd9;
        e = model(50); run_plan(1'b0, e, -1);

        // randomized runs, alternating loop-heavy and loop-light
        for (int r = 0; r < 6; r++) begin
            gen_random((r % 2 == 0) ? 85 : 0);
            e = model(50); run_plan(1'b0, e, -1);
        end

        // constant pc on the short-timeout instance: halt and timeout coincide
        clear_plan();
        for (int i = 0; i < 64; i++) pl_pc[i] = 15'd7;
        pl_we[4] = 1; pl_addr[4] = 15'd2; pl_data[4] = 16'hBEEF;
        e = model(6); run_plan(1'b1, e, -1);

        // reset pulled mid-run
        clear_plan();
        pl_we[2] = 1; pl_addr[2] = 15'd0; pl_data[2] = 16'h1234;
        e = model(50); run_plan(1'b0, e, 10);

        // recovery after the abort
        gen_random(85);
        e = model(50); run_plan(1'b0, e, -1);

        repeat (4) @(negedge clock);
        check("pending_a", 64'(exp_a.size()), 64'd0);
        check("pending_b", 64'(exp_b.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
